// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier-cell arbiter.
//   MUL_W       datapath width of operands and results
//   MAX_REQ     largest supported requester count
//   IDX_W       width of an encoded requester index
//   arb_state_e FSM states (run, drain, halt)
//   tag_t       in-flight tag: valid bit plus requester index
package mul_arb_pkg;

   localparam int unsigned MUL_W   = 32;
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = $clog2(MAX_REQ);

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StHalt
   } arb_state_e;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/mul_cell_arbiter_if.sv
// Requester-side bus of the multiplier-cell arbiter.
//   req_valid  requester i presents an operation
//   req_src1   operand A, requester i at [32i+31:32i]
//   req_src2   operand B, same packing
//   req_ready  one-hot grant
//   rsp_valid  one-hot result-valid per requester
//   rsp_result low word of src1*src2
// Modports: master = requester side, slave = arbiter side.
interface mul_cell_arbiter_if
   import mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [MUL_W*NUM_REQ-1:0] req_src1;
   logic [MUL_W*NUM_REQ-1:0] req_src2;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [MUL_W-1:0]         rsp_result;

   modport master (
      output req_valid, req_src1, req_src2,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_src1, req_src2,
      output req_ready, rsp_valid, rsp_result
   );
endinterface

// File: rtl/mul_arb_rr_picker.sv
// Combinational round-robin picker.
//   req        request vector
//   ptr        round-robin start position (must be < NUM_REQ)
//   grant      one-hot of the first set request at or after ptr, wrapping
//   grant_idx  encoded index of grant
//   grant_vld  any request set
module mul_arb_rr_picker
   import mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [IDX_W:0] cand;

   // Walk candidates in priority order ptr, ptr+1, ... (mod NUM_REQ); first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ)) begin
            cand = cand - (IDX_W+1)'(NUM_REQ);
         end
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_vld && (cand == (IDX_W+1)'(j)) && req[j]) begin
               grant[j]  = 1'b1;
               grant_idx = IDX_W'(j);
               grant_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one pipelined 32x32->32 (low word) multiplier cell among NUM_REQ requesters.
// Round-robin issue, one op per cycle; a tag pipe tracks which requester owns each
// in-flight op so the result is routed back. Quiesce drains the cell.
//   clk, reset_n         clock, asynchronous active-low reset
//   bus (slave)          requester handshake and response bus
//   mul_src1/mul_src2    operands to the cell (0 when nothing granted)
//   mul_result           cell output, MUL_LATENCY cycles after operands
//   quiesce              stop granting and drain
//   idle                 nothing in flight and FSM not draining
// Build option: MUL_ARB_OUTREG_EN registers rsp_valid/rsp_result (+1 cycle latency).
module mul_cell_arbiter
   import mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MUL_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   mul_cell_arbiter_if.slave bus,
   output logic [MUL_W-1:0]  mul_src1,
   output logic [MUL_W-1:0]  mul_src2,
   input  logic [MUL_W-1:0]  mul_result,
   input  logic              quiesce,
   output logic              idle
);

   arb_state_e         state_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   tag_t               tag_q [MUL_LATENCY];
   tag_t               last_tag;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_vld;
   logic               grant_en;
   logic               transfer;
   logic               pipe_empty;
   logic [NUM_REQ-1:0] rsp_valid_c;
   logic [MUL_W-1:0]   rsp_result_c;

`ifdef MUL_ARB_OUTREG_EN
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [MUL_W-1:0]   rsp_result_q;
`endif

   mul_arb_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Quiesce blocks grants in the same cycle it rises, before the FSM leaves RUN.
   assign grant_en      = (state_q == StRun) && !quiesce;
   assign bus.req_ready = grant_en ? grant : '0;
   assign transfer      = grant_en && grant_vld;

   always_comb begin
      mul_src1 = '0;
      mul_src2 = '0;
      if (grant_en) begin
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
               mul_src1 = bus.req_src1[j*MUL_W +: MUL_W];
               mul_src2 = bus.req_src2[j*MUL_W +: MUL_W];
            end
         end
      end
   end

   // Tag pipe mirrors the cell latency; stage 0 loads every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{vld: transfer, idx: grant_idx};
         for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
      end else if (transfer) begin
         rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

   assign last_tag = tag_q[MUL_LATENCY-1];

   always_comb begin
      rsp_valid_c = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (last_tag.vld && (last_tag.idx == IDX_W'(j))) begin
            rsp_valid_c[j] = 1'b1;
         end
      end
   end

   assign rsp_result_c = last_tag.vld ? mul_result : '0;

`ifdef MUL_ARB_OUTREG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_c;
         rsp_result_q <= rsp_result_c;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
`else
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_result = rsp_result_c;
`endif

   // Empty means no tag left anywhere, including the optional output register.
   always_comb begin
      pipe_empty = 1'b1;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
         if (tag_q[i].vld) begin
            pipe_empty = 1'b0;
         end
      end
`ifdef MUL_ARB_OUTREG_EN
      if (|rsp_valid_q) begin
         pipe_empty = 1'b0;
      end
`endif
   end

   assign idle = pipe_empty && (state_q != StDrain);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (quiesce) state_q <= StDrain;
            end
            StDrain: begin
               if (!quiesce) begin
                  state_q <= StRun;
               end else if (pipe_empty) begin
                  state_q <= StHalt;
               end
            end
            StHalt: begin
               if (!quiesce) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Self-checking bench for mul_cell_arbiter: two instances (latency 1 and 2) each
// driving a behavioural pipelined multiplier cell. Honours MUL_ARB_OUTREG_EN.
module tb_mul_cell_arbiter;

`ifdef MUL_ARB_OUTREG_EN
   localparam int OUTREG = 1;
`else
   localparam int OUTREG = 0;
`endif
   localparam int LAT1 = 1 + OUTREG;
   localparam int LAT2 = 2 + OUTREG;
   localparam int NV   = 17;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ready;
      logic [31:0] msrc1;
      logic [31:0] result;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        quiesce;
   logic [31:0] m1_a, m1_b, m1_r;
   logic [31:0] m2_a, m2_b, m2_r, m2_s0;
   logic        idle1, idle2;

   int checks;
   int errors;
   vec_t tab [NV];

   mul_cell_arbiter_if #(.NUM_REQ(4)) bus1 ();
   mul_cell_arbiter_if #(.NUM_REQ(4)) bus2 ();

   mul_cell_arbiter #(
      .NUM_REQ     (4),
      .MUL_LATENCY (1)
   ) dut1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus1),
      .mul_src1   (m1_a),
      .mul_src2   (m1_b),
      .mul_result (m1_r),
      .quiesce    (1'b0),
      .idle       (idle1)
   );

   mul_cell_arbiter #(
      .NUM_REQ     (4),
      .MUL_LATENCY (2)
   ) dut2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus2),
      .mul_src1   (m2_a),
      .mul_src2   (m2_b),
      .mul_result (m2_r),
      .quiesce    (quiesce),
      .idle       (idle2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier cells of latency 1 and 2.
   always @(posedge clk) begin
      m1_r  <= m1_a * m1_b;
      m2_s0 <= m2_a * m2_b;
      m2_r  <= m2_s0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Requester i gets src1 = a + i, src2 = b.
   task automatic drive1(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b);
      bus1.req_valid = v;
      for (int i = 0; i < 4; i++) begin
         bus1.req_src1[i*32 +: 32] = a + 32'(i);
         bus1.req_src2[i*32 +: 32] = b;
      end
   endtask

   task automatic drive2(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b);
      bus2.req_valid = v;
      for (int i = 0; i < 4; i++) begin
         bus2.req_src1[i*32 +: 32] = a + 32'(i);
         bus2.req_src2[i*32 +: 32] = b;
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] rdy, input logic [31:0] ms1,
                               input logic [31:0] res);
      vec_t t;
      t.valid = v; t.a = a; t.b = b; t.ready = rdy; t.msrc1 = ms1; t.result = res;
      return t;
   endfunction

   initial begin
      logic [3:0]  exp_rv;
      logic [31:0] exp_rr;
      checks = 0;
      errors = 0;

      // Rows: stimulus, expected grant/operand, and the result that grant must return.
      tab[0]  = mk(4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);
      tab[1]  = mk(4'b1111, 32'd2, 32'd3, 4'b0001, 32'd2, 32'd6);
      tab[2]  = mk(4'b1111, 32'd2, 32'd3, 4'b0010, 32'd3, 32'd9);
      tab[3]  = mk(4'b1111, 32'd2, 32'd3, 4'b0100, 32'd4, 32'd12);
      tab[4]  = mk(4'b1111, 32'd2, 32'd3, 4'b1000, 32'd5, 32'd15);
      tab[5]  = mk(4'b1111, 32'd2, 32'd3, 4'b0001, 32'd2, 32'd6);
      tab[6]  = mk(4'b1111, 32'd2, 32'd3, 4'b0010, 32'd3, 32'd9);
      tab[7]  = mk(4'b1111, 32'd2, 32'd3, 4'b0100, 32'd4, 32'd12);
      tab[8]  = mk(4'b1111, 32'd2, 32'd3, 4'b1000, 32'd5, 32'd15);
      tab[9]  = mk(4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);
      tab[10] = mk(4'b0001, 32'd5, 32'd7, 4'b0001, 32'd5, 32'd35);
      tab[11] = mk(4'b0100, 32'hFFFF_FFFD, 32'd2, 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      tab[12] = mk(4'b1001, 32'h0000_FFFD, 32'h0001_0000, 4'b1000, 32'h0001_0000, 32'h0);
      tab[13] = mk(4'b1010, 32'd4, 32'd5, 4'b0010, 32'd5, 32'd25);
      tab[14] = mk(4'b1010, 32'd4, 32'd5, 4'b1000, 32'd7, 32'd35);
      tab[15] = mk(4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);
      tab[16] = mk(4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0);

      reset_n = 1'b0;
      quiesce = 1'b0;
      drive1(4'b0000, 32'd0, 32'd0);
      drive2(4'b0000, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_idle1", {31'd0, idle1}, 32'd1);
      chk("reset_idle2", {31'd0, idle2}, 32'd1);
      chk("reset_rsp_valid", {28'd0, bus1.rsp_valid}, 32'd0);
      chk("reset_rsp_result", bus1.rsp_result, 32'd0);
      chk("reset_msrc1", m1_a, 32'd0);
      reset_n = 1'b1;

      // Table: grant order, operand mux, routing and wrap-around arithmetic.
      for (int r = 0; r < NV; r++) begin
         @(negedge clk);
         drive1(tab[r].valid, tab[r].a, tab[r].b);
         #1;
         chk($sformatf("tab%0d_ready", r), {28'd0, bus1.req_ready}, {28'd0, tab[r].ready});
         chk($sformatf("tab%0d_msrc1", r), m1_a, tab[r].msrc1);
         chk($sformatf("tab%0d_msrc2", r), m1_b, (tab[r].ready != 4'b0) ? tab[r].b : 32'd0);
         if (r >= LAT1) begin
            exp_rv = tab[r-LAT1].ready;
            exp_rr = (exp_rv != 4'b0) ? tab[r-LAT1].result : 32'd0;
         end else begin
            exp_rv = 4'b0;
            exp_rr = 32'd0;
         end
         chk($sformatf("tab%0d_rsp_valid", r), {28'd0, bus1.rsp_valid}, {28'd0, exp_rv});
         chk($sformatf("tab%0d_rsp_result", r), bus1.rsp_result, exp_rr);
      end

      // Quiesce with two ops in flight on the latency-2 instance, then release.
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 0) begin
            drive2(4'b0001, 32'd3, 32'd4);
         end else if (c == 1) begin
            drive2(4'b0010, 32'd5, 32'd7);
         end else if (c < 10) begin
            quiesce = 1'b1;
            drive2(4'b1111, 32'd1, 32'd1);
         end else if (c < 12) begin
            quiesce = 1'b0;
            drive2(4'b0100, 32'd7, 32'd9);
         end else begin
            drive2(4'b0000, 32'd0, 32'd0);
         end
         #1;
         if (c == 0) exp_rv = 4'b0001;
         else if (c == 1) exp_rv = 4'b0010;
         else if (c == 11) exp_rv = 4'b0100;
         else exp_rv = 4'b0000;
         chk($sformatf("q%0d_ready", c), {28'd0, bus2.req_ready}, {28'd0, exp_rv});
         if (c == LAT2) begin
            exp_rv = 4'b0001; exp_rr = 32'd12;
         end else if (c == 1 + LAT2) begin
            exp_rv = 4'b0010; exp_rr = 32'd42;
         end else if (c == 11 + LAT2) begin
            exp_rv = 4'b0100; exp_rr = 32'd81;
         end else begin
            exp_rv = 4'b0000; exp_rr = 32'd0;
         end
         chk($sformatf("q%0d_rsp_valid", c), {28'd0, bus2.rsp_valid}, {28'd0, exp_rv});
         chk($sformatf("q%0d_rsp_result", c), bus2.rsp_result, exp_rr);
         if (c >= 2 && c <= 10) begin
            chk($sformatf("q%0d_idle", c), {31'd0, idle2}, (c >= 5 + OUTREG) ? 32'd1 : 32'd0);
         end
      end

      // Asynchronous reset with one op in flight.
      @(negedge clk);
      drive1(4'b0001, 32'd5, 32'd7);
      #1;
      chk("rst_pre_ready", {28'd0, bus1.req_ready}, 32'd1);
      @(negedge clk);
      drive1(4'b0000, 32'd0, 32'd0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_rsp_valid", {28'd0, bus1.rsp_valid}, 32'd0);
      chk("rst_rsp_result", bus1.rsp_result, 32'd0);
      chk("rst_ready", {28'd0, bus1.req_ready}, 32'd0);
      chk("rst_msrc1", m1_a, 32'd0);
      chk("rst_idle", {31'd0, idle1}, 32'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst%0d_rsp_valid", c), {28'd0, bus1.rsp_valid}, 32'd0);
      end
      // Pointer must be back at 0, so requester 0 wins over 1.
      @(negedge clk);
      drive1(4'b0011, 32'd2, 32'd2);
      #1;
      chk("post_rst_ready", {28'd0, bus1.req_ready}, 32'd1);
      @(negedge clk);
      drive1(4'b0000, 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
